// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: single-car SCAN elevator controller.
// The car keeps moving in one direction while requests remain ahead of it,
// then reverses. Requests are latched per floor in `pending` and cleared
// when the door opens at that floor.
// Optional feature macro: ELEV_ESTOP_EN adds an `estop` input that freezes
// the controller (state, floor and timer) while calls keep latching.
// Handshake: there is no valid/ready pair. call_in is a level/pulse sampled
// on every rising edge; all outputs are registered and valid every cycle.
module elevator_scan_ctrl #(
    parameter int NUM_FLOORS   = 10,
    parameter int FLOOR_W      = 4,
    parameter int TRAVEL_TICKS = 10000000,
    parameter int DOOR_TICKS   = 20000000
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef ELEV_ESTOP_EN
    input  logic                  estop,
`endif
    input  logic [NUM_FLOORS-1:0] call_in,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open,
    output logic                  idle
);

    localparam int MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int TIMER_W   = $clog2(MAX_TICKS) + 1;
    localparam logic [TIMER_W-1:0] TRAVEL_LAST = TIMER_W'(TRAVEL_TICKS - 1);
    localparam logic [TIMER_W-1:0] DOOR_LAST   = TIMER_W'(DOOR_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MOVE_UP   = 2'd1,
        S_MOVE_DOWN = 2'd2,
        S_DOOR_OPEN = 2'd3
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timer_n;
    logic                 dir_up;
    logic                 dir_up_n;
    logic [FLOOR_W-1:0]   floor_n;
    logic [FLOOR_W-1:0]   step_floor;
    logic [NUM_FLOORS-1:0] pending_n;
    logic [NUM_FLOORS-1:0] latch_mask;
    logic [NUM_FLOORS-1:0] clear_mask;
    logic [NUM_FLOORS-1:0] cur_mask;
    logic [NUM_FLOORS-1:0] step_mask;
    logic [NUM_FLOORS-1:0] ahead_mask;
    logic [NUM_FLOORS-1:0] behind_mask;

    // One-hot mask of floor f (floors >= NUM_FLOORS map to no bit).
    function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i == int'(f)) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Mask of all floors strictly above f.
    function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(f)) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Mask of all floors strictly below f.
    function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(f)) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Next-state decision: scheduling uses the registered pending set only;
    // a call arriving this cycle becomes visible to scheduling next cycle.
    always_comb begin
        state_n     = state;
        timer_n     = timer;
        dir_up_n    = dir_up;
        floor_n     = current_floor;
        clear_mask  = '0;
        ahead_mask  = '0;
        behind_mask = '0;
        cur_mask    = floor_mask(current_floor);
        step_floor  = (state == S_MOVE_UP) ? current_floor + FLOOR_W'(1)
                                           : current_floor - FLOOR_W'(1);
        step_mask   = floor_mask(step_floor);
        // A call for the floor whose door is already open is absorbed.
        latch_mask  = (state == S_DOOR_OPEN) ? (call_in & ~cur_mask) : call_in;

        case (state)
            S_IDLE: begin
                timer_n = '0;
                if (|(pending & cur_mask)) begin
                    state_n    = S_DOOR_OPEN;
                    clear_mask = cur_mask;
                end else if (|(pending & above_mask(current_floor))) begin
                    state_n  = S_MOVE_UP;
                    dir_up_n = 1'b1;
                end else if (|(pending & below_mask(current_floor))) begin
                    state_n  = S_MOVE_DOWN;
                    dir_up_n = 1'b0;
                end
            end
            S_MOVE_UP, S_MOVE_DOWN: begin
                if (timer == TRAVEL_LAST) begin
                    floor_n = step_floor;
                    timer_n = '0;
                    if (|(pending & step_mask)) begin
                        state_n    = S_DOOR_OPEN;
                        clear_mask = step_mask;
                    end else begin
                        // Nothing ahead at the new floor: reverse or rest
                        // rather than running past the end of the shaft.
                        ahead_mask  = (state == S_MOVE_UP) ? above_mask(step_floor)
                                                           : below_mask(step_floor);
                        behind_mask = (state == S_MOVE_UP) ? below_mask(step_floor)
                                                           : above_mask(step_floor);
                        if (|(pending & ahead_mask)) begin
                            state_n = state;
                        end else if (|(pending & behind_mask)) begin
                            state_n  = (state == S_MOVE_UP) ? S_MOVE_DOWN : S_MOVE_UP;
                            dir_up_n = (state == S_MOVE_DOWN);
                        end else begin
                            state_n = S_IDLE;
                        end
                    end
                end else begin
                    timer_n = timer + TIMER_W'(1);
                end
            end
            S_DOOR_OPEN: begin
                if (|(call_in & cur_mask)) begin
                    timer_n = '0;
                end else if (timer == DOOR_LAST) begin
                    timer_n     = '0;
                    ahead_mask  = dir_up ? above_mask(current_floor) : below_mask(current_floor);
                    behind_mask = dir_up ? below_mask(current_floor) : above_mask(current_floor);
                    if (|(pending & ahead_mask)) begin
                        state_n = dir_up ? S_MOVE_UP : S_MOVE_DOWN;
                    end else if (|(pending & behind_mask)) begin
                        state_n  = dir_up ? S_MOVE_DOWN : S_MOVE_UP;
                        dir_up_n = ~dir_up;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    timer_n = timer + TIMER_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

`ifdef ELEV_ESTOP_EN
        // Emergency stop: hold everything except request latching.
        if (estop) begin
            state_n    = state;
            timer_n    = timer;
            dir_up_n   = dir_up;
            floor_n    = current_floor;
            clear_mask = '0;
        end
`endif

        // Service clear wins over a simultaneous call for the same floor.
        pending_n = (pending | latch_mask) & ~clear_mask;
    end

    // Controller FSM with registered one-hot state flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            timer         <= '0;
            dir_up        <= 1'b1;
            current_floor <= '0;
            pending       <= '0;
            idle          <= 1'b1;
            moving_up     <= 1'b0;
            moving_down   <= 1'b0;
            door_open     <= 1'b0;
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            dir_up        <= dir_up_n;
            current_floor <= floor_n;
            pending       <= pending_n;
            idle          <= (state_n == S_IDLE);
            moving_up     <= (state_n == S_MOVE_UP);
            moving_down   <= (state_n == S_MOVE_DOWN);
            door_open     <= (state_n == S_DOOR_OPEN);
        end
    end

endmodule
